chord_note_player: RTL and testbench

Consumer end of the song-reader note handshake. It latches a chord of up to four notes, a duration and metadata when new_note pulses. It holds per-voice note codes and enables for the synthesis voices for `duration` beats, then pulses note_done so the reader advances. Sits between the song reader and the per-voice frequency/sample generators.

---
 rtl/chord_note_player_pkg.sv | 19 +
 rtl/chord_note_player_if.sv | 35 +++
 rtl/chord_note_player_beat_counter.sv | 29 ++
 rtl/chord_note_player.sv | 116 +++++++++++
 tb/tb_chord_note_player.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/chord_note_player_pkg.sv
// Shared widths, rest code and FSM encoding for the song-reader / note-player pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package player_defs;

    localparam int NOTE_WIDTH     = 6;
    localparam int DURATION_WIDTH = 6;
    localparam int METADATA_WIDTH = 3;

    localparam logic [NOTE_WIDTH-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/chord_note_player_if.sv
// Note handshake from the song reader plus the per-voice outputs to the generators.
// Latency: n/a (wiring only).
// Backpressure: note_done is the only flow control; the reader waits for it before the next new_note.
// master = song reader / voice consumers side, slave = chord_note_player.
interface chord_note_player_if;
    import player_defs::*;

    logic                      play;
    logic                      beat;
    logic                      new_note;
    logic [NOTE_WIDTH-1:0]     note1;
    logic [NOTE_WIDTH-1:0]     note2;
    logic [NOTE_WIDTH-1:0]     note3;
    logic [NOTE_WIDTH-1:0]     note4;
    logic [1:0]                num_notes;
    logic [DURATION_WIDTH-1:0] duration;
    logic [METADATA_WIDTH-1:0] metadata;
    logic                      note_done;
    logic                      busy;
    logic [4*NOTE_WIDTH-1:0]   voice_note;
    logic [3:0]                voice_en;
    logic [METADATA_WIDTH-1:0] voice_meta;
    logic [DURATION_WIDTH-1:0] beats_left;

    modport master (
        output play, beat, new_note, note1, note2, note3, note4, num_notes, duration, metadata,
        input  note_done, busy, voice_note, voice_en, voice_meta, beats_left
    );

    modport slave (
        input  play, beat, new_note, note1, note2, note3, note4, num_notes, duration, metadata,
        output note_done, busy, voice_note, voice_en, voice_meta, beats_left
    );

endinterface

// File: rtl/chord_note_player_beat_counter.sv
// Loadable beat down-counter with a "last beat" flag.
// Latency: load/decrement visible the cycle after the enabling edge.
// Backpressure: none; dec is ignored at zero so the count never wraps.
// Ports: clk, reset (async high), load/load_val, dec, count, last (count == 1).
module beat_counter
    import player_defs::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [DURATION_WIDTH-1:0] load_val,
    input  logic                      dec,
    output logic [DURATION_WIDTH-1:0] count,
    output logic                      last
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - DURATION_WIDTH'(1);
        end
    end

    assign last = (count == DURATION_WIDTH'(1));

endmodule

// File: rtl/chord_note_player.sv
// Latches a chord on new_note and drives per-voice notes/enables for `duration` beats, then pulses note_done.
// Latency: LOAD one cycle after new_note; note_done the cycle after the last counted beat (2 cycles for duration 0).
// Backpressure: new_note is ignored outside IDLE; play low freezes the beat count and mutes all voices.
// Ports: clk, reset (async high), bus (chord_note_player_if.slave: handshake in, voice outputs out).
// Build option: ARTICULATION_GAP_EN mutes the voices during the final beat of chords of two or more beats.
module chord_note_player
    import player_defs::*;
(
    input  logic                 clk,
    input  logic                 reset,
    chord_note_player_if.slave   bus
);

    state_t state, state_nxt;

    logic [3:0][NOTE_WIDTH-1:0] notes_q;
    logic [1:0]                 num_q;
    logic [DURATION_WIDTH-1:0]  dur_q;
    logic [METADATA_WIDTH-1:0]  meta_q;

    logic                       latch;
    logic                       cnt_load;
    logic                       cnt_dec;
    logic [DURATION_WIDTH-1:0]  cnt;
    logic                       cnt_last;
    logic [3:0]                 voice_en_c;

    beat_counter u_beat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (dur_q),
        .dec      (cnt_dec),
        .count    (cnt),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.new_note) begin
                    latch     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // Any beat here is dropped: the load takes priority in the counter.
                cnt_load  = 1'b1;
                state_nxt = (dur_q == '0) ? DONE : PLAY;
            end
            PLAY: begin
                if (bus.beat && bus.play) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Chord fields stay latched through DONE/IDLE so downstream oscillators do not glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            notes_q <= '0;
            num_q   <= '0;
            dur_q   <= '0;
            meta_q  <= '0;
        end else if (latch) begin
            notes_q <= {bus.note4, bus.note3, bus.note2, bus.note1};
            num_q   <= bus.num_notes;
            dur_q   <= bus.duration;
            meta_q  <= bus.metadata;
        end
    end

    always_comb begin
        voice_en_c = '0;
        for (int i = 0; i < 4; i++) begin
            voice_en_c[i] = (state == PLAY) && bus.play && (2'(i) <= num_q)
                            && (notes_q[i] != NOTE_REST);
        end
`ifdef ARTICULATION_GAP_EN
        // Silence the final beat so repeated identical notes are heard as separate attacks.
        if (cnt_last && (dur_q >= DURATION_WIDTH'(2))) begin
            voice_en_c = '0;
        end
`endif
    end

    assign bus.note_done  = (state == DONE);
    assign bus.busy       = (state == LOAD) || (state == PLAY);
    assign bus.voice_note = notes_q;
    assign bus.voice_en   = voice_en_c;
    assign bus.voice_meta = meta_q;
    assign bus.beats_left = (state == PLAY) ? cnt : '0;

endmodule

// File: tb/tb_chord_note_player.sv
// Scoreboarded bench for chord_note_player: note_done events are matched against queued expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_chord_note_player;
    import player_defs::*;

`ifdef ARTICULATION_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    chord_note_player_if ifc ();

    chord_note_player dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int          cyc;
        logic [23:0] vn;
        logic [2:0]  vm;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every note_done must correspond to a queued expectation with matching cycle and fields.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && ifc.note_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("done_note", 32'(ifc.voice_note), 32'(e.vn));
                check("done_meta", 32'(ifc.voice_meta), 32'(e.vm));
                check("done_busy", 32'(ifc.busy), 32'd0);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        ifc.beat     = 1'b0;
        ifc.new_note = 1'b0;
    endtask

    task automatic issue(input logic [5:0] n1, input logic [5:0] n2, input logic [5:0] n3,
                         input logic [5:0] n4, input logic [1:0] num, input logic [5:0] dur,
                         input logic [2:0] meta, input logic with_beat);
        nxt();
        ifc.note1     = n1;
        ifc.note2     = n2;
        ifc.note3     = n3;
        ifc.note4     = n4;
        ifc.num_notes = num;
        ifc.duration  = dur;
        ifc.metadata  = meta;
        ifc.new_note  = 1'b1;
        ifc.beat      = with_beat;
    endtask

    // k beats, one every `gap` cycles; optionally expect note_done right after the last one.
    task automatic beats(input int k, input int gap, input bit push_last,
                         input logic [23:0] vn, input logic [2:0] vm);
        for (int j = 0; j < k; j++) begin
            repeat (gap - 1) nxt();
            nxt();
            ifc.beat = 1'b1;
            if (push_last && j == k - 1) sb.push_back('{cyc: cyc + 1, vn: vn, vm: vm});
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_done"}, 32'(ifc.note_done), 32'd0);
        check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
        check({tag, "_vnote"}, 32'(ifc.voice_note), 32'd0);
        check({tag, "_ven"}, 32'(ifc.voice_en), 32'd0);
        check({tag, "_vmeta"}, 32'(ifc.voice_meta), 32'd0);
        check({tag, "_left"}, 32'(ifc.beats_left), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        ifc.play = 1'b1; ifc.beat = 1'b0; ifc.new_note = 1'b0;
        ifc.note1 = '0; ifc.note2 = '0; ifc.note3 = '0; ifc.note4 = '0;
        ifc.num_notes = '0; ifc.duration = '0; ifc.metadata = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;

        // Reset mid-PLAY: chord abandoned, no note_done.
        issue(6'd12, 6'd0, 6'd0, 6'd0, 2'd0, 6'd10, 3'd3, 1'b0);
        nxt(); nxt();
        beats(3, 4, 1'b0, 24'd0, 3'd0);
        nxt();
        check("midplay_left", 32'(ifc.beats_left), 32'd7);
        reset = 1'b1;
        #1;
        check_idle_zero("midreset");
        nxt();
        reset = 1'b0;

        // Single note, duration 3, beats every 8 cycles.
        issue(6'd20, 6'd0, 6'd0, 6'd0, 2'd0, 6'd3, 3'd5, 1'b0);
        nxt();
        check("t2_load_busy", 32'(ifc.busy), 32'd1);
        check("t2_load_ven", 32'(ifc.voice_en), 32'd0);
        nxt();
        check("t2_play_ven", 32'(ifc.voice_en), 32'b0001);
        check("t2_play_note", 32'(ifc.voice_note), 32'd20);
        check("t2_play_left", 32'(ifc.beats_left), 32'd3);
        beats(3, 8, 1'b1, 24'd20, 3'd5);
        nxt();
        check("t2_done_ven", 32'(ifc.voice_en), 32'd0);
        nxt();
        check("t2_idle_done", 32'(ifc.note_done), 32'd0);
        check("t2_idle_hold", 32'(ifc.voice_note), 32'd20);

        // Four-voice chord with a rest; beats during new_note and LOAD are not counted.
        issue(6'd20, 6'd27, 6'd32, 6'd0, 2'd3, 6'd2, 3'd2, 1'b1);
        nxt();
        ifc.beat = 1'b1;
        check("t3_load_left", 32'(ifc.beats_left), 32'd0);
        nxt();
        check("t3_play_left", 32'(ifc.beats_left), 32'd2);
        check("t3_play_ven", 32'(ifc.voice_en), 32'b0111);
        beats(2, 4, 1'b1, {6'd0, 6'd32, 6'd27, 6'd20}, 3'd2);
        nxt(); nxt();

        // Duration 0: LOAD then DONE, voices never enabled.
        issue(6'd9, 6'd0, 6'd0, 6'd0, 2'd0, 6'd0, 3'd1, 1'b0);
        sb.push_back('{cyc: cyc + 2, vn: 24'd9, vm: 3'd1});
        nxt();
        check("t4_load_busy", 32'(ifc.busy), 32'd1);
        check("t4_load_ven", 32'(ifc.voice_en), 32'd0);
        nxt();
        check("t4_done_ven", 32'(ifc.voice_en), 32'd0);
        nxt();

        // Pause: beats during pause are lost, injected new_note ignored.
        issue(6'd33, 6'd0, 6'd0, 6'd0, 2'd0, 6'd4, 3'd6, 1'b0);
        nxt(); nxt();
        beats(1, 4, 1'b0, 24'd0, 3'd0);
        nxt();
        check("t5_pre_left", 32'(ifc.beats_left), 32'd3);
        ifc.play = 1'b0;
        for (int i = 0; i < 20; i++) begin
            nxt();
            ifc.beat = (i == 5 || i == 15);
            if (i == 10) begin
                ifc.note1 = 6'd7; ifc.num_notes = 2'd3; ifc.duration = 6'd1; ifc.metadata = 3'd0;
                ifc.new_note = 1'b1;
            end
        end
        nxt();
        check("t5_pause_left", 32'(ifc.beats_left), 32'd3);
        check("t5_pause_ven", 32'(ifc.voice_en), 32'd0);
        check("t5_pause_busy", 32'(ifc.busy), 32'd1);
        check("t5_pause_note", 32'(ifc.voice_note), 32'd33);
        ifc.play = 1'b1;
        #1;
        check("t5_resume_ven", 32'(ifc.voice_en), 32'b0001);
        beats(3, 4, 1'b1, 24'd33, 3'd6);
        nxt();
        ifc.note1 = 6'd44; ifc.duration = 6'd5; ifc.new_note = 1'b1;
        nxt();
        check("t5_ign_busy", 32'(ifc.busy), 32'd0);
        check("t5_ign_note", 32'(ifc.voice_note), 32'd33);
        nxt();
        check("t5_ign_busy2", 32'(ifc.busy), 32'd0);

        // Articulation gap on the final beat (build dependent); none for a one-beat chord.
        issue(6'd40, 6'd0, 6'd0, 6'd0, 2'd0, 6'd3, 3'd4, 1'b0);
        nxt(); nxt();
        check("t6_first_ven", 32'(ifc.voice_en), 32'b0001);
        beats(2, 4, 1'b0, 24'd0, 3'd0);
        nxt();
        check("t6_last_left", 32'(ifc.beats_left), 32'd1);
        check("t6_gap_ven", 32'(ifc.voice_en), GAP ? 32'd0 : 32'b0001);
        beats(1, 4, 1'b1, 24'd40, 3'd4);
        nxt(); nxt();

        issue(6'd41, 6'd0, 6'd0, 6'd0, 2'd0, 6'd1, 3'd0, 1'b0);
        nxt(); nxt();
        check("t6_d1_ven", 32'(ifc.voice_en), 32'b0001);
        beats(1, 3, 1'b1, 24'd41, 3'd0);
        nxt(); nxt();

        repeat (3) nxt();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
